mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access pipeline stage placed directly after the EX/MEM buffer. It consumes the decoded EX/MEM fields (ALU result, store data, control bits, destination register) and performs scalar or vectorial loads/stores against a single-port, one-word-per-access data memory. Vector accesses are serialised one lane per cycle, and the stage stalls upstream while busy. It registers the result into the MEM/WB stage for writeback and forwarding.

## Interface
Parameters:
- N, 24, lane/word width in bits
- M, 6, number of vector lanes
- AW, 16, data-memory address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- modeSel  in  1  0 = scalar, 1 = vectorial
- aluResult  in  M*N  EX result; bits [AW-1:0] of lane 0 are the base address
- rd3  in  M*N  store data (lane k in bits [(k+1)*N-1:k*N])
- memWrite  in  1  store request
- memToReg  in  1  load request
- regWrite  in  1  writeback enable
- Rc  in  4  destination register
- stall  out  1  hold request to EX/MEM and earlier stages (upstream en = ~stall)
- mem_addr  out  AW  data-memory word address
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_wdata  out  N  memory write data
- mem_rdata  in  N  memory read data, valid the cycle after mem_re
- wb_valid  out  1  MEM/WB entry holds a real instruction
- wb_regWrite  out  1  registered regWrite, gated by wb_valid
- wb_modeSel  out  1  registered modeSel
- wb_Rc  out  4  registered Rc
- wb_result  out  M*N  writeback data (ALU result or loaded data)

## Operation
- Op class from inputs in IDLE: memWrite=1 gives STORE (takes priority if both set); otherwise memToReg=1 gives LOAD; otherwise ALU.
- FSM states: IDLE, STORE_V, LOAD_S, LOAD_V. Lane counter `lane` runs 0..M-1.
- ALU op: no memory strobes. stall=0. WB registers capture aluResult and control at the end of the cycle.
- Scalar store: in the same cycle, mem_we=1, mem_addr=base, mem_wdata=rd3 lane 0, stall=0. WB captures the entry with wb_result=aluResult.
- Vector store: cycle k (k=0..M-1) drives mem_we=1, mem_addr=base+k, mem_wdata=rd3 lane k. The FSM enters STORE_V after cycle 0. stall=1 in cycles 0..M-2 and stall=0 in cycle M-1. WB captures in cycle M-1.
- Scalar load: cycle 0 drives mem_re=1, mem_addr=base, stall=1, and moves to LOAD_S. In cycle 1, mem_rdata is captured into lane 0 of wb_result, upper lanes are zero, and stall=0.
- Vector load: cycle k (0..M-1) drives mem_re=1 and mem_addr=base+k. Lane k data arrives in cycle k+1 and is written into the assembly register lane k. stall=1 in cycles 0..M-1 and stall=0 in cycle M. In cycle M, WB captures the assembled vector with lane M-1 taken directly from mem_rdata.
- Address arithmetic: base+k is computed modulo 2^AW, wrapping with no flag.
- Non-IDLE states ignore input fields; upstream holds them stable because of stall.
- Any cycle that does not complete an instruction loads a bubble into WB: wb_valid=0, wb_regWrite=0, other WB fields unchanged.

## Timing
- Reset values: state IDLE, lane 0, wb_valid=0, wb_regWrite=0, wb_modeSel=0, wb_Rc=0, wb_result=0, assembly register 0.
- While rst=1: stall, mem_we and mem_re are forced to 0 combinationally. mem_addr and mem_wdata are 0.
- Reset mid-operation aborts the access. Writes already issued remain in memory. No further strobes are issued, and no partial WB entry is produced.
- Latency from inputs valid to WB valid:
  - ALU op and scalar store: 1 edge.
  - Scalar load: 2 edges.
  - Vector store: M edges.
  - Vector load: M+1 edges.
- stall, mem_* are combinational from state, lane and inputs. wb_* are registered.
- Back-to-back: a new instruction may be decoded in the cycle immediately after the completing cycle (the FSM is back in IDLE).

## Structure
- Package mem_stage_pkg holds:
  - state enum (IDLE, STORE_V, LOAD_S, LOAD_V);
  - op-class enum (OP_ALU, OP_LOAD, OP_STORE);
  - lane-index width localparam $clog2(M).
- One sub-module, load_assembler: M×N register with per-lane write enable plus clear. It is written by the FSM using lane index and mem_rdata.
- The FSM, counter, address adder and WB register live in the top module.

## Test plan
- ALU op, aluResult lane0=0x000123, regWrite=1, Rc=5 -> after 1 edge wb_valid=1, wb_Rc=5, wb_result lane0=0x000123; stall never asserted.
- Scalar store, base 0x0010, rd3 lane0=0xABCDEF -> same cycle mem_we=1, mem_addr=0x0010, mem_wdata=0xABCDEF, stall=0.
- Scalar load, base 0x0020, memory[0x20]=0x00BEEF -> stall=1 for exactly 1 cycle; after 2 edges wb_result lane0=0x00BEEF and upper lanes 0. The intervening WB entry is a bubble.
- Vector store, base 0x0030, lanes 1..6 -> mem_we on 6 consecutive cycles at addresses 0x30..0x35 with data 1..6; stall high for 5 cycles.
- Vector load, base 0xFFFE, AW=16 -> reads 0xFFFE, 0xFFFF, 0x0000..0x0003; stall high for 6 cycles; the WB vector holds lanes in order after 7 edges.
- rst=1 in cycle 3 of a vector load -> during reset, mem_re=0 and stall=0; next cycle state IDLE, wb_valid=0, wb_result=0; no further memory strobes.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage.
//   state_e : FSM states of mem_access_stage
//   op_e    : operation class decoded from the EX/MEM control bits
//   lane_w  : lane-index width for a given lane count (at least 1 bit)
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STORE_V = 2'd1,
        LOAD_S  = 2'd2,
        LOAD_V  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_e;

    function automatic int lane_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int M_DEFAULT = 6;
    localparam int LANE_W    = lane_w(M_DEFAULT);

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of EX/MEM inputs, data-memory port, stall and MEM/WB outputs.
//   slave  : the memory-access stage itself
//   master : the surrounding pipeline / memory / testbench
interface mem_access_stage_if #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int AW = 16
);
    // EX/MEM fields
    logic           modeSel;
    logic [M*N-1:0] aluResult;
    logic [M*N-1:0] rd3;
    logic           memWrite;
    logic           memToReg;
    logic           regWrite;
    logic [3:0]     Rc;
    // upstream hold
    logic           stall;
    // data memory
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic           mem_re;
    logic [N-1:0]   mem_wdata;
    logic [N-1:0]   mem_rdata;
    // MEM/WB
    logic           wb_valid;
    logic           wb_regWrite;
    logic           wb_modeSel;
    logic [3:0]     wb_Rc;
    logic [M*N-1:0] wb_result;

    modport slave (
        input  modeSel, aluResult, rd3, memWrite, memToReg, regWrite, Rc, mem_rdata,
        output stall, mem_addr, mem_we, mem_re, mem_wdata,
               wb_valid, wb_regWrite, wb_modeSel, wb_Rc, wb_result
    );

    modport master (
        output modeSel, aluResult, rd3, memWrite, memToReg, regWrite, Rc, mem_rdata,
        input  stall, mem_addr, mem_we, mem_re, mem_wdata,
               wb_valid, wb_regWrite, wb_modeSel, wb_Rc, wb_result
    );
endinterface

// File: rtl/load_assembler.sv
// M x N assembly register for vector loads.
//   clk, rst : clock, synchronous active-high reset (clears all lanes)
//   clr_i    : clear all lanes
//   we_i     : write wdata_i into lane lane_i
//   q_o      : assembled lanes, lane k in q_o[k]
module load_assembler #(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int LW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [LW-1:0]        lane_i,
    input  logic [N-1:0]         wdata_i,
    output logic [M-1:0][N-1:0]  q_o
);
    logic [N-1:0] lane_q [M];

    for (genvar g = 0; g < M; g++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst || clr_i)
                lane_q[g] <= '0;
            else if (we_i && lane_i == LW'(g))
                lane_q[g] <= wdata_i;
        end
        assign q_o[g] = lane_q[g];
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: scalar/vector loads and stores against a
// single-port one-word-per-access memory, vector lanes serialised one per
// cycle, result registered into MEM/WB.
//   clk, rst : clock, synchronous active-high reset
//   bus      : EX/MEM inputs, stall, data-memory port, MEM/WB outputs
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int N  = 24,
    parameter int M  = 6,
    parameter int AW = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_stage_if.slave bus
);
    localparam int             LW   = lane_w(M);
    localparam logic [LW-1:0]  LAST = LW'(M - 1);

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    op_e             op;
    logic [AW-1:0]   base;
    logic            done;
    logic [M*N-1:0]  res_d;
    logic            asm_clr, asm_we;
    logic [M-1:0][N-1:0] asm_q;

    logic            stall_raw, we_raw, re_raw;
    logic [AW-1:0]   addr_raw;
    logic [N-1:0]    wdata_raw;

    logic            wb_valid_q, wb_regWrite_q, wb_modeSel_q;
    logic [3:0]      wb_Rc_q;
    logic [M*N-1:0]  wb_result_q;

    assign base = bus.aluResult[AW-1:0];

    // store wins when both request bits are set
    always_comb begin
        op = OP_ALU;
        if (bus.memWrite)      op = OP_STORE;
        else if (bus.memToReg) op = OP_LOAD;
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        stall_raw = 1'b0;
        we_raw    = 1'b0;
        re_raw    = 1'b0;
        addr_raw  = '0;
        wdata_raw = '0;
        done      = 1'b0;
        asm_clr   = 1'b0;
        asm_we    = 1'b0;
        res_d     = bus.aluResult;
        case (state_q)
            IDLE: begin
                case (op)
                    OP_ALU: done = 1'b1;
                    OP_STORE: begin
                        we_raw    = 1'b1;
                        addr_raw  = base;
                        wdata_raw = bus.rd3[N-1:0];
                        if (bus.modeSel && M > 1) begin
                            stall_raw = 1'b1;
                            state_d   = STORE_V;
                            lane_d    = LW'(1);
                        end else begin
                            done = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        re_raw    = 1'b1;
                        addr_raw  = base;
                        stall_raw = 1'b1;
                        if (bus.modeSel) begin
                            state_d = LOAD_V;
                            lane_d  = '0;
                            asm_clr = 1'b1;
                        end else begin
                            state_d = LOAD_S;
                        end
                    end
                    default: ;
                endcase
            end
            // lane_q is the lane being written this cycle
            STORE_V: begin
                we_raw    = 1'b1;
                addr_raw  = base + AW'(lane_q);
                wdata_raw = bus.rd3[int'(lane_q)*N +: N];
                if (lane_q == LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    lane_d  = '0;
                end else begin
                    stall_raw = 1'b1;
                    lane_d    = lane_q + LW'(1);
                end
            end
            LOAD_S: begin
                done            = 1'b1;
                state_d         = IDLE;
                res_d           = '0;
                res_d[N-1:0]    = bus.mem_rdata;
            end
            // lane_q is the lane whose data arrives this cycle; the read for
            // the following lane is issued in parallel
            LOAD_V: begin
                asm_we = 1'b1;
                if (lane_q == LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    lane_d  = '0;
                    res_d   = asm_q;
                    res_d[(M-1)*N +: N] = bus.mem_rdata;
                end else begin
                    re_raw    = 1'b1;
                    addr_raw  = base + AW'(lane_q) + AW'(1);
                    stall_raw = 1'b1;
                    lane_d    = lane_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    load_assembler #(.N(N), .M(M), .LW(LW)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (asm_clr),
        .we_i    (asm_we),
        .lane_i  (lane_q),
        .wdata_i (bus.mem_rdata),
        .q_o     (asm_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_regWrite_q <= 1'b0;
            wb_modeSel_q  <= 1'b0;
            wb_Rc_q       <= '0;
            wb_result_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (done) begin
                wb_valid_q    <= 1'b1;
                wb_regWrite_q <= bus.regWrite;
                wb_modeSel_q  <= bus.modeSel;
                wb_Rc_q       <= bus.Rc;
                wb_result_q   <= res_d;
            end else begin
                wb_valid_q    <= 1'b0;
                wb_regWrite_q <= 1'b0;
            end
        end
    end

    // reset silences the memory port immediately, not just from the next edge
    assign bus.stall     = stall_raw & ~rst;
    assign bus.mem_we    = we_raw & ~rst;
    assign bus.mem_re    = re_raw & ~rst;
    assign bus.mem_addr  = rst ? '0 : addr_raw;
    assign bus.mem_wdata = rst ? '0 : wdata_raw;

    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_regWrite = wb_regWrite_q;
    assign bus.wb_modeSel  = wb_modeSel_q;
    assign bus.wb_Rc       = wb_Rc_q;
    assign bus.wb_result   = wb_result_q;
endmodule
